// File: rtl/sdram_avalon_local_bridge.sv
// Avalon-MM slave front end for the half-rate DDR SDRAM controller local interface.
// One-deep command holding register, outstanding-read limiter and registered read return.
module sdram_avalon_local_bridge #(
  parameter int unsigned DATA_BITS   = 64,
  parameter int unsigned ROW_BITS    = 13,
  parameter int unsigned BANK_BITS   = 2,
  parameter int unsigned COL_BITS    = 9,
  parameter int unsigned MAX_RD_PEND = 4,
  parameter int unsigned AW          = ROW_BITS + BANK_BITS + COL_BITS - 1,
  parameter int unsigned BEW         = DATA_BITS / 8
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic [AW-1:0]        avs_address,
  input  logic                 avs_read,
  input  logic                 avs_write,
  input  logic [DATA_BITS-1:0] avs_writedata,
  input  logic [BEW-1:0]       avs_byteenable,
  output logic                 avs_waitrequest,
  output logic [DATA_BITS-1:0] avs_readdata,
  output logic                 avs_readdatavalid,
  input  logic                 local_init_done,
  input  logic                 local_ready,
  input  logic [DATA_BITS-1:0] local_rdata,
  input  logic                 local_rdata_valid,
  output logic                 local_read_req,
  output logic                 local_write_req,
  output logic                 local_burstbegin,
  output logic [ROW_BITS-1:0]  local_row_addr,
  output logic [BANK_BITS-1:0] local_bank_addr,
  output logic [COL_BITS-2:0]  local_col_addr,
  output logic                 local_cs_addr,
  output logic                 local_size,
  output logic [DATA_BITS-1:0] local_wdata,
  output logic [BEW-1:0]       local_be,
  output logic                 local_autopch_req,
  output logic                 local_refresh_req,
  output logic                 local_powerdn_req,
  output logic                 local_self_rfsh_req,
  output logic                 rd_underflow_err
);

  typedef enum logic [0:0] {StInit, StRun} state_e;

  state_e               state_q, state_d;
  logic                 cmd_valid_q;
  logic                 cmd_rd_q;
  logic                 first_q;
  logic [AW-1:0]        cmd_addr_q;
  logic [DATA_BITS-1:0] wdata_q;
  logic [BEW-1:0]       be_q;
  logic [3:0]           rd_cnt_q;
  logic                 underflow_q;
  logic                 rdv_q;
  logic [DATA_BITS-1:0] rdata_q;

  logic rd_full;
  logic accept;
  logic rd_inc;

  always_comb begin
    state_d = state_q;
    if (state_q == StInit && local_init_done) begin
      state_d = StRun;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= StInit;
    end else begin
      state_q <= state_d;
    end
  end

  assign rd_full         = (rd_cnt_q == 4'(MAX_RD_PEND));
  assign avs_waitrequest = (state_q == StInit) | (cmd_valid_q & ~local_ready) | (avs_read & rd_full);
  assign accept          = (avs_read | avs_write) & ~avs_waitrequest;
  assign rd_inc          = accept & avs_read;

  // Command holding register; a new accept may overwrite in the same cycle the old one issues.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cmd_valid_q <= 1'b0;
      cmd_rd_q    <= 1'b0;
      first_q     <= 1'b0;
      cmd_addr_q  <= '0;
      wdata_q     <= '0;
      be_q        <= '0;
    end else begin
      if (accept) begin
        cmd_valid_q <= 1'b1;
        cmd_rd_q    <= avs_read;
        first_q     <= 1'b1;
        cmd_addr_q  <= avs_address;
        wdata_q     <= avs_writedata;
        be_q        <= avs_byteenable;
      end else begin
        if (cmd_valid_q) begin
          first_q <= 1'b0;
        end
        if (cmd_valid_q && local_ready) begin
          cmd_valid_q <= 1'b0;
        end
      end
    end
  end

  // Outstanding read count; a return with nothing pending flags a sticky error.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rd_cnt_q    <= '0;
      underflow_q <= 1'b0;
    end else begin
      if (rd_inc && !local_rdata_valid) begin
        rd_cnt_q <= rd_cnt_q + 4'd1;
      end else if (!rd_inc && local_rdata_valid) begin
        if (rd_cnt_q != 4'd0) begin
          rd_cnt_q <= rd_cnt_q - 4'd1;
        end else begin
          underflow_q <= 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rdv_q   <= 1'b0;
      rdata_q <= '0;
    end else begin
      rdv_q   <= local_rdata_valid;
      rdata_q <= local_rdata;
    end
  end

  assign local_read_req      = cmd_valid_q & cmd_rd_q;
  assign local_write_req     = cmd_valid_q & ~cmd_rd_q;
  assign local_burstbegin    = cmd_valid_q & first_q;
  assign local_row_addr      = cmd_addr_q[AW-1 -: ROW_BITS];
  assign local_bank_addr     = cmd_addr_q[AW-1-ROW_BITS -: BANK_BITS];
  assign local_col_addr      = cmd_addr_q[COL_BITS-2:0];
  assign local_wdata         = wdata_q;
  assign local_be            = be_q;
  assign local_cs_addr       = 1'b0;
  assign local_size          = 1'b1;
  assign local_autopch_req   = 1'b0;
  assign local_refresh_req   = 1'b0;
  assign local_powerdn_req   = 1'b0;
  assign local_self_rfsh_req = 1'b0;
  assign avs_readdatavalid   = rdv_q;
  assign avs_readdata        = rdata_q;
  assign rd_underflow_err    = underflow_q;

endmodule

// File: tb/tb_sdram_avalon_local_bridge.sv
// Directed bench for sdram_avalon_local_bridge: inputs driven at the falling edge,
// outputs checked 1 ns later, expected values hand-computed per scenario.
module tb_sdram_avalon_local_bridge;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [22:0] avs_address;
  logic        avs_read, avs_write;
  logic [63:0] avs_writedata;
  logic [7:0]  avs_byteenable;
  logic        avs_waitrequest;
  logic [63:0] avs_readdata;
  logic        avs_readdatavalid;
  logic        local_init_done, local_ready;
  logic [63:0] local_rdata;
  logic        local_rdata_valid;
  logic        local_read_req, local_write_req, local_burstbegin;
  logic [12:0] local_row_addr;
  logic [1:0]  local_bank_addr;
  logic [7:0]  local_col_addr;
  logic        local_cs_addr, local_size;
  logic [63:0] local_wdata;
  logic [7:0]  local_be;
  logic        local_autopch_req, local_refresh_req, local_powerdn_req, local_self_rfsh_req;
  logic        rd_underflow_err;

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  sdram_avalon_local_bridge dut (
    .clk                 (clk),
    .reset_n             (reset_n),
    .avs_address         (avs_address),
    .avs_read            (avs_read),
    .avs_write           (avs_write),
    .avs_writedata       (avs_writedata),
    .avs_byteenable      (avs_byteenable),
    .avs_waitrequest     (avs_waitrequest),
    .avs_readdata        (avs_readdata),
    .avs_readdatavalid   (avs_readdatavalid),
    .local_init_done     (local_init_done),
    .local_ready         (local_ready),
    .local_rdata         (local_rdata),
    .local_rdata_valid   (local_rdata_valid),
    .local_read_req      (local_read_req),
    .local_write_req     (local_write_req),
    .local_burstbegin    (local_burstbegin),
    .local_row_addr      (local_row_addr),
    .local_bank_addr     (local_bank_addr),
    .local_col_addr      (local_col_addr),
    .local_cs_addr       (local_cs_addr),
    .local_size          (local_size),
    .local_wdata         (local_wdata),
    .local_be            (local_be),
    .local_autopch_req   (local_autopch_req),
    .local_refresh_req   (local_refresh_req),
    .local_powerdn_req   (local_powerdn_req),
    .local_self_rfsh_req (local_self_rfsh_req),
    .rd_underflow_err    (rd_underflow_err)
  );

  task automatic test_reset;
    #3;
    vectors++;
    if (avs_waitrequest !== 1'b1) begin
      miscompares++; $display("FAIL reset_wait: got %b want 1", avs_waitrequest);
    end
    vectors++;
    if (local_size !== 1'b1) begin
      miscompares++; $display("FAIL reset_size: got %b want 1", local_size);
    end
    vectors++;
    if ({local_read_req, local_write_req, local_burstbegin, avs_readdatavalid, rd_underflow_err,
         local_cs_addr, local_autopch_req, local_refresh_req, local_powerdn_req,
         local_self_rfsh_req} !== 10'b0) begin
      miscompares++; $display("FAIL reset_ctrl: got %b%b%b%b%b want 00000", local_read_req,
                              local_write_req, local_burstbegin, avs_readdatavalid, rd_underflow_err);
    end
    vectors++;
    if ({local_wdata, local_be, local_row_addr, avs_readdata} !== '0) begin
      miscompares++; $display("FAIL reset_data: got wdata %h be %h want 0", local_wdata, local_be);
    end
  endtask

  task automatic test_init_wait;
    @(negedge clk);
    reset_n        = 1'b1;
    avs_write      = 1'b1;
    avs_address    = 23'h123456;
    avs_writedata  = 64'hA5A5_A5A5_A5A5_A5A5;
    avs_byteenable = 8'hFF;
    local_ready    = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk); #1;
      vectors++;
      if (avs_waitrequest !== 1'b1 || local_write_req !== 1'b0) begin
        miscompares++; $display("FAIL init_wait[%0d]: got wait %b wreq %b want 1 0", i,
                                avs_waitrequest, local_write_req);
      end
    end
  endtask

  task automatic test_write;
    @(negedge clk);
    local_init_done = 1'b1;
    #1;
    vectors++;
    if (avs_waitrequest !== 1'b1) begin
      miscompares++; $display("FAIL write_still_init: got %b want 1", avs_waitrequest);
    end
    @(negedge clk); #1;
    vectors++;
    if (avs_waitrequest !== 1'b0) begin
      miscompares++; $display("FAIL write_run_wait: got %b want 0", avs_waitrequest);
    end
    @(negedge clk);
    avs_write = 1'b0;
    #1;
    vectors++;
    if (local_write_req !== 1'b1 || local_read_req !== 1'b0 || local_burstbegin !== 1'b1) begin
      miscompares++; $display("FAIL write_req: got w%b r%b bb%b want w1 r0 bb1", local_write_req,
                              local_read_req, local_burstbegin);
    end
    vectors++;
    if (local_row_addr !== 13'h048D || local_bank_addr !== 2'd0 || local_col_addr !== 8'h56) begin
      miscompares++; $display("FAIL write_fields: got %h/%h/%h want 048d/0/56", local_row_addr,
                              local_bank_addr, local_col_addr);
    end
    vectors++;
    if (local_wdata !== 64'hA5A5_A5A5_A5A5_A5A5 || local_be !== 8'hFF) begin
      miscompares++; $display("FAIL write_data: got %h/%h want a5a5a5a5a5a5a5a5/ff", local_wdata,
                              local_be);
    end
    @(negedge clk); #1;
    vectors++;
    if (local_write_req !== 1'b0 || local_burstbegin !== 1'b0) begin
      miscompares++; $display("FAIL write_one_cycle: got w%b bb%b want 0 0", local_write_req,
                              local_burstbegin);
    end
  endtask

  task automatic test_stall;
    @(negedge clk);
    local_ready    = 1'b0;
    avs_write      = 1'b1;
    avs_address    = 23'h7FFFFF;
    avs_writedata  = 64'h0123_4567_89AB_CDEF;
    avs_byteenable = 8'h0F;
    #1;
    vectors++;
    if (avs_waitrequest !== 1'b0) begin
      miscompares++; $display("FAIL stall_accept: got %b want 0", avs_waitrequest);
    end
    @(negedge clk);
    avs_write      = 1'b0;
    avs_writedata  = '0;
    avs_byteenable = '0;
    for (int i = 0; i < 5; i++) begin
      if (i > 0) @(negedge clk);
      #1;
      vectors++;
      if (local_write_req !== 1'b1 || local_burstbegin !== (i == 0) || avs_waitrequest !== 1'b1)
      begin
        miscompares++; $display("FAIL stall_hold[%0d]: got w%b bb%b wait%b want 1 %0d 1", i,
                                local_write_req, local_burstbegin, avs_waitrequest, i == 0);
      end
      vectors++;
      if (local_row_addr !== 13'h1FFF || local_bank_addr !== 2'd3 || local_col_addr !== 8'hFF ||
          local_wdata !== 64'h0123_4567_89AB_CDEF || local_be !== 8'h0F) begin
        miscompares++; $display("FAIL stall_fields[%0d]: got %h/%h/%h %h %h", i, local_row_addr,
                                local_bank_addr, local_col_addr, local_wdata, local_be);
      end
    end
    @(negedge clk);
    local_ready = 1'b1;
    #1;
    vectors++;
    if (local_write_req !== 1'b1 || local_burstbegin !== 1'b0 || avs_waitrequest !== 1'b0) begin
      miscompares++; $display("FAIL stall_release: got w%b bb%b wait%b want 1 0 0",
                              local_write_req, local_burstbegin, avs_waitrequest);
    end
    @(negedge clk); #1;
    vectors++;
    if (local_write_req !== 1'b0) begin
      miscompares++; $display("FAIL stall_issued: got %b want 0", local_write_req);
    end
  endtask

  task automatic test_back_to_back;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      avs_read    = 1'b1;
      avs_address = 23'(k + 1);
      #1;
      vectors++;
      if (avs_waitrequest !== 1'b0) begin
        miscompares++; $display("FAIL b2b_wait[%0d]: got %b want 0", k, avs_waitrequest);
      end
      if (k > 0) begin
        vectors++;
        if (local_read_req !== 1'b1 || local_burstbegin !== 1'b1 || local_col_addr !== 8'(k)) begin
          miscompares++; $display("FAIL b2b_cmd[%0d]: got r%b bb%b col %h want 1 1 %h", k,
                                  local_read_req, local_burstbegin, local_col_addr, 8'(k));
        end
      end
    end
    @(negedge clk);
    avs_address = 23'd5;
    #1;
    vectors++;
    if (avs_waitrequest !== 1'b1 || local_read_req !== 1'b1 || local_col_addr !== 8'h04) begin
      miscompares++; $display("FAIL b2b_full: got wait%b r%b col %h want 1 1 04", avs_waitrequest,
                              local_read_req, local_col_addr);
    end
    for (int i = 0; i < 2; i++) begin
      @(negedge clk); #1;
      vectors++;
      if (avs_waitrequest !== 1'b1 || local_read_req !== 1'b0) begin
        miscompares++; $display("FAIL b2b_blocked[%0d]: got wait%b r%b want 1 0", i,
                                avs_waitrequest, local_read_req);
      end
    end
    @(negedge clk);
    local_rdata_valid = 1'b1;
    local_rdata       = 64'hDEAD_BEEF_0000_0001;
    #1;
    vectors++;
    if (avs_waitrequest !== 1'b1 || avs_readdatavalid !== 1'b0) begin
      miscompares++; $display("FAIL b2b_pulse: got wait%b rdv%b want 1 0", avs_waitrequest,
                              avs_readdatavalid);
    end
    @(negedge clk);
    local_rdata_valid = 1'b0;
    #1;
    vectors++;
    if (avs_waitrequest !== 1'b0) begin
      miscompares++; $display("FAIL b2b_slot_free: got %b want 0", avs_waitrequest);
    end
    vectors++;
    if (avs_readdatavalid !== 1'b1 || avs_readdata !== 64'hDEAD_BEEF_0000_0001) begin
      miscompares++; $display("FAIL rdata_latency: got v%b %h want 1 deadbeef00000001",
                              avs_readdatavalid, avs_readdata);
    end
    @(negedge clk); #1;
    vectors++;
    if (avs_readdatavalid !== 1'b0 || local_read_req !== 1'b1 || local_burstbegin !== 1'b1 ||
        local_col_addr !== 8'h05 || avs_waitrequest !== 1'b1) begin
      miscompares++; $display("FAIL b2b_fifth: got rdv%b r%b bb%b col %h wait%b want 0 1 1 05 1",
                              avs_readdatavalid, local_read_req, local_burstbegin, local_col_addr,
                              avs_waitrequest);
    end
    avs_read = 1'b0;
  endtask

  task automatic test_read_return;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      local_rdata_valid = 1'b1;
      local_rdata       = 64'h100 + 64'(i);
      #1;
      vectors++;
      if (avs_readdatavalid !== (i > 0) ||
          (i > 0 && avs_readdata !== 64'h100 + 64'(i - 1))) begin
        miscompares++; $display("FAIL ret[%0d]: got v%b %h", i, avs_readdatavalid, avs_readdata);
      end
    end
    @(negedge clk);
    local_rdata_valid = 1'b0;
    #1;
    vectors++;
    if (avs_readdatavalid !== 1'b1 || avs_readdata !== 64'h103) begin
      miscompares++; $display("FAIL ret_last: got v%b %h want 1 103", avs_readdatavalid,
                              avs_readdata);
    end
    @(negedge clk); #1;
    vectors++;
    if (avs_readdatavalid !== 1'b0 || rd_underflow_err !== 1'b0) begin
      miscompares++; $display("FAIL ret_done: got rdv%b err%b want 0 0", avs_readdatavalid,
                              rd_underflow_err);
    end
  endtask

  task automatic test_underflow;
    @(negedge clk);
    local_rdata_valid = 1'b1;
    local_rdata       = 64'h55;
    #1;
    vectors++;
    if (rd_underflow_err !== 1'b0) begin
      miscompares++; $display("FAIL uflow_pre: got %b want 0", rd_underflow_err);
    end
    @(negedge clk);
    local_rdata_valid = 1'b0;
    #1;
    vectors++;
    if (rd_underflow_err !== 1'b1) begin
      miscompares++; $display("FAIL uflow_set: got %b want 1", rd_underflow_err);
    end
    for (int i = 0; i < 3; i++) begin
      @(negedge clk); #1;
      vectors++;
      if (rd_underflow_err !== 1'b1) begin
        miscompares++; $display("FAIL uflow_sticky[%0d]: got %b want 1", i, rd_underflow_err);
      end
    end
  endtask

  task automatic test_reset_mid;
    @(negedge clk);
    local_ready    = 1'b0;
    avs_write      = 1'b1;
    avs_address    = 23'h000ABC;
    avs_writedata  = 64'hFFFF_FFFF_FFFF_FFFF;
    avs_byteenable = 8'hFF;
    @(negedge clk);
    avs_write         = 1'b0;
    local_rdata_valid = 1'b1;
    #1;
    vectors++;
    if (local_write_req !== 1'b1) begin
      miscompares++; $display("FAIL mid_pending: got %b want 1", local_write_req);
    end
    #1 reset_n = 1'b0;
    #1;
    vectors++;
    if (local_write_req !== 1'b0 || local_burstbegin !== 1'b0 || avs_waitrequest !== 1'b1 ||
        avs_readdatavalid !== 1'b0 || rd_underflow_err !== 1'b0 || local_size !== 1'b1) begin
      miscompares++; $display("FAIL mid_reset_ctrl: got w%b bb%b wait%b rdv%b err%b size%b",
                              local_write_req, local_burstbegin, avs_waitrequest,
                              avs_readdatavalid, rd_underflow_err, local_size);
    end
    vectors++;
    if (local_wdata !== 64'h0 || local_be !== 8'h0 || local_col_addr !== 8'h0) begin
      miscompares++; $display("FAIL mid_reset_data: got %h %h %h want 0", local_wdata, local_be,
                              local_col_addr);
    end
    @(negedge clk);
    reset_n           = 1'b1;
    local_rdata_valid = 1'b0;
    local_ready       = 1'b1;
    #1;
    vectors++;
    if (avs_waitrequest !== 1'b1 || avs_readdatavalid !== 1'b0) begin
      miscompares++; $display("FAIL mid_release: got wait%b rdv%b want 1 0", avs_waitrequest,
                              avs_readdatavalid);
    end
    @(negedge clk); #1;
    vectors++;
    if (avs_waitrequest !== 1'b0 || avs_readdatavalid !== 1'b0 || local_write_req !== 1'b0) begin
      miscompares++; $display("FAIL mid_after: got wait%b rdv%b w%b want 0 0 0", avs_waitrequest,
                              avs_readdatavalid, local_write_req);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    reset_n           = 1'b0;
    avs_address       = '0;
    avs_read          = 1'b0;
    avs_write         = 1'b0;
    avs_writedata     = '0;
    avs_byteenable    = '0;
    local_init_done   = 1'b0;
    local_ready       = 1'b0;
    local_rdata       = '0;
    local_rdata_valid = 1'b0;
    test_reset;
    test_init_wait;
    test_write;
    test_stall;
    test_back_to_back;
    test_read_return;
    test_underflow;
    test_reset_mid;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
